// File: rtl/mem_arb_ctrl_if.sv
// Request/response bundle between N requesters and the shared word RAM.
// master: drives req/we/addr/wdata/be; slave: drives gnt/rvalid/rdata/busy/err.
interface mem_arb_ctrl_if #(
   parameter int N_CH   = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   logic [N_CH-1:0]        req;
   logic [N_CH-1:0]        we;
   logic [N_CH*ADDR_W-1:0] addr;
   logic [N_CH*DATA_W-1:0] wdata;
   logic [N_CH*BE_W-1:0]   be;
   logic [N_CH-1:0]        gnt;
   logic [N_CH-1:0]        rvalid;
   logic [DATA_W-1:0]      rdata;
   logic                   busy;
   logic                   err;

   modport master (
      output req, we, addr, wdata, be,
      input  gnt, rvalid, rdata, busy, err
   );

   modport slave (
      input  req, we, addr, wdata, be,
      output gnt, rvalid, rdata, busy, err
   );
endinterface

// File: rtl/mem_arb_ctrl.sv
// Round-robin arbiter + wait-state FSM in front of a byte-enable word RAM.
// Ports: clk, rst (async active-low), bus (mem_arb_ctrl_if.slave).
// Optional MEM_RANGE_CHK_EN: flag misaligned / out-of-range addresses via err.
module mem_arb_ctrl #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int DEPTH       = 256,
   parameter int N_CH        = 2,
   parameter int WAIT_CYCLES = 2
) (
   input logic          clk,
   input logic          rst,
   mem_arb_ctrl_if.slave bus
);
   localparam int BE_W  = DATA_W / 8;
   localparam int OFF_W = $clog2(BE_W);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PW    = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BE_W - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACCESS,
      RESP
   } state_t;

   state_t state, state_nxt;

   logic [PW-1:0]     rr_ptr;
   logic [PW-1:0]     win;
   logic              win_vld;
   logic [ADDR_W-1:0] win_addr;
   logic              win_err;
   int                arb_j;

   logic [CW-1:0]     wcnt;
   logic              wait_done;

   logic [PW-1:0]     lat_ch;
   logic              lat_we;
   logic [IDX_W-1:0]  lat_idx;
   logic [DATA_W-1:0] lat_wdata;
   logic [BE_W-1:0]   lat_be;
   logic              lat_err;

   logic [N_CH-1:0]   gnt_q;
   logic [N_CH-1:0]   rvalid_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;

   logic [DATA_W-1:0] mem [DEPTH];

   // Scan from rr_ptr upward; lowest offset k is assigned last and wins.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      arb_j   = 0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         arb_j = int'(rr_ptr) + k;
         if (arb_j >= N_CH) arb_j = arb_j - N_CH;
         if (bus.req[PW'(arb_j)]) begin
            win     = PW'(arb_j);
            win_vld = 1'b1;
         end
      end
   end

   assign win_addr = bus.addr[int'(win)*ADDR_W +: ADDR_W];

`ifdef MEM_RANGE_CHK_EN
   assign win_err = ((win_addr & OFF_MASK) != '0) ||
                    ((win_addr >> (OFF_W + IDX_W)) != '0);
`else
   assign win_err = 1'b0;
`endif

   assign wait_done = (wcnt == CW'(WAIT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:
            if (win_vld)
               state_nxt = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
         WAIT:
            if (wait_done) state_nxt = ACCESS;
         ACCESS:
            state_nxt = RESP;
         RESP:
            state_nxt = IDLE;
         default:
            state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr    <= '0;
         wcnt      <= '0;
         lat_ch    <= '0;
         lat_we    <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= '0;
         lat_be    <= '0;
         lat_err   <= 1'b0;
         gnt_q     <= '0;
         rvalid_q  <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         gnt_q    <= '0;
         rvalid_q <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;

         if (state == WAIT) wcnt <= wcnt + 1'b1;
         else               wcnt <= '0;

         if (state == IDLE && win_vld) begin
            gnt_q     <= N_CH'(1) << win;
            lat_ch    <= win;
            lat_we    <= bus.we[win];
            lat_idx   <= win_addr[OFF_W +: IDX_W];
            lat_wdata <= bus.wdata[int'(win)*DATA_W +: DATA_W];
            lat_be    <= bus.be[int'(win)*BE_W +: BE_W];
            lat_err   <= win_err;
            rr_ptr    <= (int'(win) == N_CH - 1) ? '0 : win + 1'b1;
         end

         // Read data is captured here and shown only for the RESP cycle.
         if (state == ACCESS) begin
            rvalid_q <= N_CH'(1) << lat_ch;
            rdata_q  <= (lat_we || lat_err) ? '0 : mem[lat_idx];
            err_q    <= lat_err;
         end
      end
   end

   // Write commits only on the ACCESS edge, so an aborted txn never lands.
   always_ff @(posedge clk) begin
      if (rst && state == ACCESS && lat_we && !lat_err) begin
         for (int i = 0; i < BE_W; i++) begin
            if (lat_be[i]) mem[lat_idx][i*8 +: 8] <= lat_wdata[i*8 +: 8];
         end
      end
   end

   assign bus.gnt    = gnt_q;
   assign bus.rvalid = rvalid_q;
   assign bus.rdata  = rdata_q;
   assign bus.err    = err_q;
   assign bus.busy   = (state != IDLE);

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Directed bench for mem_arb_ctrl: two instances (WAIT_CYCLES=2 and 0).
// Covers reset, handshake timing, byte enables, wrap, round-robin, req drop.
module tb_mem_arb_ctrl;
   logic clk;
   logic rst;
   int   errors;
   int   checks;

   mem_arb_ctrl_if #(.N_CH(2), .ADDR_W(32), .DATA_W(32)) b0 ();
   mem_arb_ctrl_if #(.N_CH(2), .ADDR_W(32), .DATA_W(32)) b1 ();

   mem_arb_ctrl #(
      .DATA_W(32), .ADDR_W(32), .DEPTH(256), .N_CH(2), .WAIT_CYCLES(0)
   ) u_w0 (
      .clk(clk), .rst(rst), .bus(b0)
   );

   mem_arb_ctrl #(
      .DATA_W(32), .ADDR_W(32), .DEPTH(256), .N_CH(2), .WAIT_CYCLES(2)
   ) u_w2 (
      .clk(clk), .rst(rst), .bus(b1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  gnt;
      logic [1:0]  rvalid;
      logic [31:0] rdata;
      logic        busy;
      logic        err;
   } obs_t;

   function automatic obs_t sample(input int d);
      obs_t o;
      if (d == 0) o = '{b0.gnt, b0.rvalid, b0.rdata, b0.busy, b0.err};
      else        o = '{b1.gnt, b1.rvalid, b1.rdata, b1.busy, b1.err};
      return o;
   endfunction

   task automatic chk(input string tag, input logic [31:0] o,
                      input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic drive(input int d, input int ch, input bit r,
                        input bit w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b);
      if (d == 0) begin
         b0.req[ch]          = r;
         b0.we[ch]           = w;
         b0.addr[ch*32 +: 32]  = a;
         b0.wdata[ch*32 +: 32] = wd;
         b0.be[ch*4 +: 4]      = b;
      end else begin
         b1.req[ch]          = r;
         b1.we[ch]           = w;
         b1.addr[ch*32 +: 32]  = a;
         b1.wdata[ch*32 +: 32] = wd;
         b1.be[ch*4 +: 4]      = b;
      end
   endtask

   // Issue one transaction; gnt expected in cycle 1, rvalid in W+2.
   task automatic txn(input int d, input int ch, input bit w,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] b, input string tag,
                      output logic [31:0] rd, output logic er);
      int   gc;
      int   rc;
      int   lat;
      obs_t o;
      gc  = 0;
      rc  = 0;
      rd  = '0;
      er  = 1'b0;
      lat = (d == 0) ? 2 : 4;
      @(negedge clk);
      drive(d, ch, 1'b1, w, a, wd, b);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         o = sample(d);
         if (o.gnt[ch] && gc == 0) gc = c;
         if (o.rvalid[ch]) begin
            rc = c;
            rd = o.rdata;
            er = o.err;
            break;
         end
      end
      drive(d, ch, 1'b0, 1'b0, '0, '0, '0);
      chk({tag, ".gnt_cyc"}, gc, 1);
      chk({tag, ".rvalid_cyc"}, rc, lat);
   endtask

   task automatic chk_idle(input string tag);
      obs_t o;
      o = sample(1);
      chk({tag, ".gnt"}, {30'd0, o.gnt}, 32'd0);
      chk({tag, ".rvalid"}, {30'd0, o.rvalid}, 32'd0);
      chk({tag, ".rdata"}, o.rdata, 32'd0);
      chk({tag, ".busy"}, {31'd0, o.busy}, 32'd0);
      chk({tag, ".err"}, {31'd0, o.err}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      obs_t        o;
      int          n;
      int          gch [4];
      int          gcy [4];
      int          rv_n;
      int          rv_c;
      int          g_n;

      errors = 0;
      checks = 0;
      rst    = 1'b0;
      b0.req = '0; b0.we = '0; b0.addr = '0; b0.wdata = '0; b0.be = '0;
      b1.req = '0; b1.we = '0; b1.addr = '0; b1.wdata = '0; b1.be = '0;
      repeat (2) @(negedge clk);
      chk_idle("reset");
      rst = 1'b1;

      txn(1, 1, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, "wr40", rd, er);
      chk("wr40.rdata", rd, 32'h0);
      txn(1, 0, 1'b0, 32'h40, 32'h0, 4'h0, "rd40", rd, er);
      chk("rd40.rdata", rd, 32'hDEADBEEF);

      txn(1, 1, 1'b1, 32'h40, 32'h11223344, 4'b0101, "wrbe", rd, er);
      txn(1, 0, 1'b0, 32'h40, 32'h0, 4'h0, "rdbe", rd, er);
      chk("rdbe.rdata", rd, 32'hDE22BE44);

      txn(1, 0, 1'b0, 32'h440, 32'h0, 4'h0, "rd440", rd, er);
`ifdef MEM_RANGE_CHK_EN
      chk("rd440.rdata", rd, 32'h0);
      chk("rd440.err", {31'd0, er}, 32'd1);
`else
      chk("rd440.rdata", rd, 32'hDE22BE44);
      chk("rd440.err", {31'd0, er}, 32'd0);
`endif

      // ch0 drops req right after its grant.
      @(negedge clk);
      drive(1, 0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
      @(negedge clk);
      o = sample(1);
      chk("drop.gnt", {30'd0, o.gnt}, 32'd1);
      drive(1, 0, 1'b0, 1'b0, '0, '0, '0);
      rv_n = 0;
      rv_c = 0;
      g_n  = 0;
      for (int c = 2; c <= 14; c++) begin
         @(negedge clk);
         o = sample(1);
         if (o.rvalid[0]) begin
            rv_n++;
            rv_c = c;
         end
         if (o.gnt[0]) g_n++;
      end
      chk("drop.rvalid_cnt", rv_n, 1);
      chk("drop.rvalid_cyc", rv_c, 4);
      chk("drop.regrant", g_n, 0);

      txn(1, 1, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, "wr10", rd, er);

      // Reset during WAIT of a write to 0x10.
      @(negedge clk);
      drive(1, 1, 1'b1, 1'b1, 32'h10, 32'h12345678, 4'hF);
      @(negedge clk);
      o = sample(1);
      chk("abort.gnt", {30'd0, o.gnt}, 32'd2);
      drive(1, 1, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_idle("abort");
      @(negedge clk);
      rst = 1'b1;

      // Round-robin with both channels held high from reset.
      @(negedge clk);
      drive(1, 0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      drive(1, 1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
      n = 0;
      for (int i = 0; i < 4; i++) begin
         gch[i] = -1;
         gcy[i] = 0;
      end
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         o = sample(1);
         if (o.gnt != 2'b00) begin
            gch[n] = o.gnt[1] ? 1 : 0;
            gcy[n] = c;
            n++;
            if (n == 4) break;
         end
      end
      drive(1, 0, 1'b0, 1'b0, '0, '0, '0);
      drive(1, 1, 1'b0, 1'b0, '0, '0, '0);
      chk("rr.count", n, 4);
      chk("rr.first_cyc", gcy[0], 1);
      for (int i = 0; i < 4; i++) chk($sformatf("rr.ch%0d", i), gch[i], i % 2);
      for (int i = 0; i < 3; i++)
         chk($sformatf("rr.gap%0d", i), gcy[i+1] - gcy[i], 5);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (!b1.busy) break;
      end
      chk("rr.drain", {31'd0, b1.busy}, 32'd0);

      txn(1, 0, 1'b0, 32'h10, 32'h0, 4'h0, "rd10", rd, er);
      chk("rd10.rdata", rd, 32'hCAFEF00D);

      // Zero wait-state instance: wrap / range behaviour.
      txn(0, 0, 1'b1, 32'h0, 32'hA5A55A5A, 4'hF, "w0wr0", rd, er);
      txn(0, 1, 1'b0, 32'h400, 32'h0, 4'h0, "w0rd400", rd, er);
`ifdef MEM_RANGE_CHK_EN
      chk("w0rd400.rdata", rd, 32'h0);
      chk("w0rd400.err", {31'd0, er}, 32'd1);
`else
      chk("w0rd400.rdata", rd, 32'hA5A55A5A);
      chk("w0rd400.err", {31'd0, er}, 32'd0);
`endif
      txn(0, 1, 1'b1, 32'h400, 32'h0BADF00D, 4'hF, "w0wr400", rd, er);
      txn(0, 0, 1'b0, 32'h0, 32'h0, 4'h0, "w0rd0", rd, er);
`ifdef MEM_RANGE_CHK_EN
      chk("w0rd0.rdata", rd, 32'hA5A55A5A);
`else
      chk("w0rd0.rdata", rd, 32'h0BADF00D);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
